// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - shared constants and FSM encoding for the LC3 data-memory responder
package lc3_pkg;

  localparam logic [15:0] MMIO_BASE = 16'hFE00;
  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;

  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/lc3_dmem_ram.sv
// rtl/lc3_dmem_ram.sv - single-port synchronous 2^ADDR_W x 16 data RAM
module lc3_dmem_ram #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [15:0]       i_wdata,
  output logic [15:0]       o_rdata
);

  logic [15:0] r_mem [2**ADDR_W];
  logic [15:0] r_rdata;

  // Read register only updates on a read so it holds across writes.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/lc3_dmem_responder.sv
// rtl/lc3_dmem_responder.sv - LC3 data-memory responder with wait states, RAM and keyboard/display MMIO
module lc3_dmem_responder
  import lc3_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem_en,
  input  logic        dmem_rd,
  input  logic [15:0] dmem_addr,
  input  logic [15:0] dmem_din,
  output logic [15:0] dmem_dout,
  output logic        dmem_ready,
  input  logic        kb_valid,
  input  logic [7:0]  kb_char,
  output logic        disp_valid,
  output logic [7:0]  disp_data,
  input  logic        disp_ack
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_wait_cnt;
  logic [15:0] r_addr;
  logic [15:0] r_din;
  logic        r_rd;
  logic        r_ready;
  logic        r_sel_ram;
  logic [15:0] r_mmio_dout;
  logic        r_kb_rdy;
  logic [7:0]  r_kb_buf;
  logic        r_disp_valid;
  logic [7:0]  r_disp_data;

  logic        w_resp;
  logic        w_is_ram;
  logic        w_ram_we;
  logic        w_ram_re;
  logic        w_mmio_rd;
  logic        w_ddr_wr;
  logic        w_kbdr_rd;
  logic [15:0] w_mmio_rdata;
  logic [15:0] w_ram_rdata;

  assign w_resp    = (r_state == ST_RESP) && !rst;
  assign w_is_ram  = (r_addr < MMIO_BASE);
  assign w_ram_we  = w_resp && (r_rd == MEM_WRITE) && w_is_ram;
  assign w_ram_re  = w_resp && (r_rd == MEM_READ) && w_is_ram;
  assign w_mmio_rd = w_resp && (r_rd == MEM_READ) && !w_is_ram;
  assign w_ddr_wr  = w_resp && (r_rd == MEM_WRITE) && (r_addr == DDR_ADDR);
  assign w_kbdr_rd = w_mmio_rd && (r_addr == KBDR_ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (dmem_en) w_next_state = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (r_wait_cnt == 4'd0) w_next_state = ST_RESP;
      ST_RESP: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= 4'd0;
      r_addr     <= 16'h0000;
      r_din      <= 16'h0000;
      r_rd       <= MEM_READ;
    end else if (r_state == ST_IDLE && dmem_en) begin
      r_wait_cnt <= WAIT_LOAD;
      r_addr     <= dmem_addr;
      r_din      <= dmem_din;
      r_rd       <= dmem_rd;
    end else if (r_state == ST_WAIT && r_wait_cnt != 4'd0) begin
      r_wait_cnt <= r_wait_cnt - 4'd1;
    end
  end

  always_comb begin
    w_mmio_rdata = 16'h0000;
    case (r_addr)
      KBSR_ADDR: w_mmio_rdata = {r_kb_rdy, 15'b0};
      KBDR_ADDR: w_mmio_rdata = {8'h00, r_kb_buf};
      DSR_ADDR:  w_mmio_rdata = {~r_disp_valid, 15'b0};
      default:   w_mmio_rdata = 16'h0000;
    endcase
  end

  // dmem_dout selects between the RAM read register and the MMIO read register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready     <= 1'b0;
      r_sel_ram   <= 1'b0;
      r_mmio_dout <= 16'h0000;
    end else begin
      r_ready <= w_resp;
      if (w_ram_re) begin
        r_sel_ram <= 1'b1;
      end else if (w_mmio_rd) begin
        r_sel_ram   <= 1'b0;
        r_mmio_dout <= w_mmio_rdata;
      end
    end
  end

  // A new keyboard character beats a same-cycle KBDR read clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_kb_rdy <= 1'b0;
      r_kb_buf <= 8'h00;
    end else if (kb_valid) begin
      r_kb_rdy <= 1'b1;
      r_kb_buf <= kb_char;
    end else if (w_kbdr_rd) begin
      r_kb_rdy <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_disp_valid <= 1'b0;
      r_disp_data  <= 8'h00;
    end else if (r_disp_valid && disp_ack) begin
      r_disp_valid <= 1'b0;
    end else if (w_ddr_wr && !r_disp_valid) begin
      r_disp_valid <= 1'b1;
      r_disp_data  <= r_din[7:0];
    end
  end

  lc3_dmem_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_addr  (r_addr[ADDR_W-1:0]),
    .i_wdata (r_din),
    .o_rdata (w_ram_rdata)
  );

  assign dmem_dout  = r_sel_ram ? w_ram_rdata : r_mmio_dout;
  assign dmem_ready = r_ready;
  assign disp_valid = r_disp_valid;
  assign disp_data  = r_disp_data;

endmodule

// File: tb/tb_lc3_dmem_responder.sv
// tb/tb_lc3_dmem_responder.sv - self-checking bench for lc3_dmem_responder
module tb_lc3_dmem_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        dmem_en, dmem_rd;
  logic [15:0] dmem_addr, dmem_din, dmem_dout;
  logic        dmem_ready;
  logic        kb_valid;
  logic [7:0]  kb_char;
  logic        disp_valid;
  logic [7:0]  disp_data;
  logic        disp_ack;

  logic        d0_en, d0_rd;
  logic [15:0] d0_addr, d0_din, d0_dout;
  logic        d0_ready;
  logic        d0_kb_valid;
  logic [7:0]  d0_kb_char;
  logic        d0_disp_valid;
  logic [7:0]  d0_disp_data;
  logic        d0_disp_ack;

  lc3_dmem_responder #(.ADDR_W(12), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .dmem_en(dmem_en), .dmem_rd(dmem_rd),
    .dmem_addr(dmem_addr), .dmem_din(dmem_din), .dmem_dout(dmem_dout),
    .dmem_ready(dmem_ready), .kb_valid(kb_valid), .kb_char(kb_char),
    .disp_valid(disp_valid), .disp_data(disp_data), .disp_ack(disp_ack)
  );

  lc3_dmem_responder #(.ADDR_W(12), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .dmem_en(d0_en), .dmem_rd(d0_rd),
    .dmem_addr(d0_addr), .dmem_din(d0_din), .dmem_dout(d0_dout),
    .dmem_ready(d0_ready), .kb_valid(d0_kb_valid), .kb_char(d0_kb_char),
    .disp_valid(d0_disp_valid), .disp_data(d0_disp_data), .disp_ack(d0_disp_ack)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one request on the WAIT_CYCLES=2 instance; called and returns at posedge+1.
  task automatic do_req(input bit rd, input logic [15:0] a, input logic [15:0] d,
                        output logic [15:0] q, output int lat);
    dmem_en = 1'b1; dmem_rd = rd; dmem_addr = a; dmem_din = d;
    @(posedge clk); #1;
    dmem_en = 1'b0;
    lat = 0; q = 16'h0000;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (dmem_ready) begin
        lat = i; q = dmem_dout;
        break;
      end
    end
    if (lat != 0) begin
      @(posedge clk); #1;
      chk("ready_one_cycle", {15'b0, dmem_ready}, 16'h0000);
    end
  endtask

  task automatic pulse_kb(input logic [7:0] c);
    kb_valid = 1'b1; kb_char = c;
    @(posedge clk); #1;
    kb_valid = 1'b0;
  endtask

  task automatic pulse_ack();
    disp_ack = 1'b1;
    @(posedge clk); #1;
    disp_ack = 1'b0;
  endtask

  typedef struct {
    string       name;
    bit          rd;
    logic [15:0] addr;
    logic [15:0] din;
    bit          kb;
    logic [7:0]  kbc;
    bit          ack;
    logic [15:0] exp;
    bit          exp_dv;
    logic [7:0]  exp_dd;
  } vec_t;

  vec_t vecs[$];

  bit          m_kb_rdy, m_dv;
  logic [7:0]  m_kb_buf, m_dd;
  logic [15:0] m_mem [int];
  logic [11:0] idx_set [16];

  initial begin
    logic [15:0] q;
    int          lat;
    int          cnt;
    logic [5:0]  pat;

    rst = 1'b1; dmem_en = 0; dmem_rd = 0; dmem_addr = 0; dmem_din = 0;
    kb_valid = 0; kb_char = 0; disp_ack = 0;
    d0_en = 0; d0_rd = 0; d0_addr = 0; d0_din = 0;
    d0_kb_valid = 0; d0_kb_char = 0; d0_disp_ack = 0;

    vecs.push_back('{"wr_0010",    0, 16'h0010, 16'h1234, 0, 8'h00, 0, 16'h0000, 0, 8'h00});
    vecs.push_back('{"rd_0010",    1, 16'h0010, 16'h0000, 0, 8'h00, 0, 16'h1234, 0, 8'h00});
    vecs.push_back('{"kbsr_set",   1, 16'hFE00, 16'h0000, 1, 8'h41, 0, 16'h8000, 0, 8'h00});
    vecs.push_back('{"kbdr_rd",    1, 16'hFE02, 16'h0000, 0, 8'h00, 0, 16'h0041, 0, 8'h00});
    vecs.push_back('{"kbsr_clr",   1, 16'hFE00, 16'h0000, 0, 8'h00, 0, 16'h0000, 0, 8'h00});
    vecs.push_back('{"wr_kbsr",    0, 16'hFE00, 16'hFFFF, 0, 8'h00, 0, 16'h0000, 0, 8'h00});
    vecs.push_back('{"kbsr_still", 1, 16'hFE00, 16'h0000, 0, 8'h00, 0, 16'h0000, 0, 8'h00});
    vecs.push_back('{"ddr_wr58",   0, 16'hFE06, 16'h0058, 0, 8'h00, 0, 16'h0000, 1, 8'h58});
    vecs.push_back('{"dsr_busy",   1, 16'hFE04, 16'h0000, 0, 8'h00, 0, 16'h0000, 1, 8'h58});
    vecs.push_back('{"ddr_drop59", 0, 16'hFE06, 16'h0059, 0, 8'h00, 0, 16'h0000, 1, 8'h58});
    vecs.push_back('{"ddr_rd",     1, 16'hFE06, 16'h0000, 0, 8'h00, 0, 16'h0000, 1, 8'h58});
    vecs.push_back('{"dsr_ack",    1, 16'hFE04, 16'h0000, 0, 8'h00, 1, 16'h8000, 0, 8'h58});
    vecs.push_back('{"unmapped",   1, 16'hFE08, 16'h0000, 0, 8'h00, 0, 16'h0000, 0, 8'h58});
    vecs.push_back('{"wr_alias",   0, 16'h1010, 16'hABCD, 0, 8'h00, 0, 16'h0000, 0, 8'h58});
    vecs.push_back('{"rd_alias",   1, 16'h0010, 16'h0000, 0, 8'h00, 0, 16'hABCD, 0, 8'h58});
    vecs.push_back('{"wr_kbdr",    0, 16'hFE02, 16'h1111, 0, 8'h00, 0, 16'h0000, 0, 8'h58});
    vecs.push_back('{"kbdr_keep",  1, 16'hFE02, 16'h0000, 0, 8'h00, 0, 16'h0041, 0, 8'h58});
    vecs.push_back('{"rd_fffe",    1, 16'hFFFE, 16'h0000, 0, 8'h00, 0, 16'h0000, 0, 8'h58});

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_ready", {15'b0, dmem_ready}, 16'h0000);
    chk("rst_dout", dmem_dout, 16'h0000);
    chk("rst_disp_valid", {15'b0, disp_valid}, 16'h0000);
    chk("rst_disp_data", {8'h00, disp_data}, 16'h0000);
    do_req(1, 16'hFE00, 0, q, lat); chk("rst_kbsr", q, 16'h0000);
    do_req(1, 16'hFE02, 0, q, lat); chk("rst_kbdr", q, 16'h0000);

    foreach (vecs[i]) begin
      if (vecs[i].kb) pulse_kb(vecs[i].kbc);
      if (vecs[i].ack) pulse_ack();
      do_req(vecs[i].rd, vecs[i].addr, vecs[i].din, q, lat);
      chk({vecs[i].name, "_lat"}, 16'(lat), 16'd3);
      if (vecs[i].rd) chk({vecs[i].name, "_data"}, q, vecs[i].exp);
      chk({vecs[i].name, "_dv"}, {15'b0, disp_valid}, {15'b0, vecs[i].exp_dv});
      chk({vecs[i].name, "_dd"}, {8'h00, disp_data}, {8'h00, vecs[i].exp_dd});
    end

    // Keyboard collision: new char lands in the KBDR read's RESP cycle.
    pulse_kb(8'h41);
    dmem_en = 1; dmem_rd = 1; dmem_addr = 16'hFE02;
    @(posedge clk); #1 dmem_en = 0;
    @(posedge clk);
    @(posedge clk); #1 kb_valid = 1; kb_char = 8'h42;
    @(posedge clk); #1 kb_valid = 0;
    chk("kbcol_ready", {15'b0, dmem_ready}, 16'h0001);
    chk("kbcol_data", dmem_dout, 16'h0041);
    @(posedge clk); #1;
    do_req(1, 16'hFE00, 0, q, lat); chk("kbcol_kbsr", q, 16'h8000);
    do_req(1, 16'hFE02, 0, q, lat); chk("kbcol_kbdr", q, 16'h0042);
    do_req(1, 16'hFE00, 0, q, lat); chk("kbcol_kbsr2", q, 16'h0000);

    // Display collision: ack arrives in the RESP cycle of a second DDR write.
    do_req(0, 16'hFE06, 16'h0058, q, lat);
    chk("dcol_pre_dv", {15'b0, disp_valid}, 16'h0001);
    dmem_en = 1; dmem_rd = 0; dmem_addr = 16'hFE06; dmem_din = 16'h005A;
    @(posedge clk); #1 dmem_en = 0;
    @(posedge clk);
    @(posedge clk); #1 disp_ack = 1;
    @(posedge clk); #1 disp_ack = 0;
    chk("dcol_ready", {15'b0, dmem_ready}, 16'h0001);
    chk("dcol_dv", {15'b0, disp_valid}, 16'h0000);
    chk("dcol_dd", {8'h00, disp_data}, 16'h0058);
    @(posedge clk); #1;
    do_req(1, 16'hFE04, 0, q, lat); chk("dcol_dsr", q, 16'h8000);

    // Reset in the middle of a write.
    do_req(0, 16'h0020, 16'h5555, q, lat);
    pulse_kb(8'h77);
    do_req(0, 16'hFE06, 16'h0033, q, lat);
    chk("dout_hold_after_wr", dmem_dout, 16'h8000);
    dmem_en = 1; dmem_rd = 0; dmem_addr = 16'h0020; dmem_din = 16'hFFFF;
    @(posedge clk); #1 dmem_en = 0;
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    chk("mrst_ready", {15'b0, dmem_ready}, 16'h0000);
    chk("mrst_dout", dmem_dout, 16'h0000);
    chk("mrst_dv", {15'b0, disp_valid}, 16'h0000);
    chk("mrst_dd", {8'h00, disp_data}, 16'h0000);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (dmem_ready) cnt++;
    end
    chk("mrst_no_ready", 16'(cnt), 16'd0);
    do_req(1, 16'hFE00, 0, q, lat); chk("mrst_kbsr", q, 16'h0000);
    do_req(1, 16'h0020, 0, q, lat); chk("mrst_ram_kept", q, 16'h5555);

    // Randomized traffic against a transaction-level model.
    m_kb_rdy = 0; m_kb_buf = 8'h00; m_dv = 0; m_dd = 8'h00;
    foreach (idx_set[i]) idx_set[i] = 12'($urandom_range(0, 4095));
    for (int t = 0; t < 200; t++) begin
      int          kind;
      int          ix;
      logic [15:0] a, d, e;
      bit          rd;
      kind = $urandom_range(0, 9);
      if ($urandom_range(0, 4) == 0) begin
        logic [7:0] c;
        c = 8'($urandom);
        pulse_kb(c); m_kb_rdy = 1; m_kb_buf = c;
      end
      if ($urandom_range(0, 3) == 0) begin
        pulse_ack(); m_dv = 0;
      end
      e = 16'h0000;
      d = 16'($urandom);
      if (kind < 5) begin
        ix = $urandom_range(0, 15);
        a = {4'($urandom_range(0, 14)), idx_set[ix]};
        rd = m_mem.exists(int'(idx_set[ix])) && ($urandom_range(0, 1) == 1);
        if (rd) e = m_mem[int'(idx_set[ix])];
        else m_mem[int'(idx_set[ix])] = d;
      end else begin
        case ($urandom_range(0, 5))
          0: a = 16'hFE00;
          1: a = 16'hFE02;
          2: a = 16'hFE04;
          3: a = 16'hFE06;
          4: a = 16'hFE0A;
          default: a = 16'hFF00 | 16'($urandom_range(0, 255));
        endcase
        rd = ($urandom_range(0, 1) == 1);
        if (rd) begin
          if (a == 16'hFE00) e = m_kb_rdy ? 16'h8000 : 16'h0000;
          else if (a == 16'hFE02) begin e = {8'h00, m_kb_buf}; m_kb_rdy = 0; end
          else if (a == 16'hFE04) e = m_dv ? 16'h0000 : 16'h8000;
        end else if (a == 16'hFE06 && !m_dv) begin
          m_dv = 1; m_dd = d[7:0];
        end
      end
      do_req(rd, a, d, q, lat);
      chk("rand_lat", 16'(lat), 16'd3);
      if (rd) chk("rand_data", q, e);
      chk("rand_dv", {15'b0, disp_valid}, {15'b0, m_dv});
      chk("rand_dd", {8'h00, disp_data}, {8'h00, m_dd});
    end

    // WAIT_CYCLES = 0 instance.
    d0_en = 1; d0_rd = 0; d0_addr = 16'h0FFF; d0_din = 16'hBEEF;
    @(posedge clk); #1 d0_en = 0;
    chk("w0_wr_no_early", {15'b0, d0_ready}, 16'h0000);
    @(posedge clk); #1;
    chk("w0_wr_ready", {15'b0, d0_ready}, 16'h0001);
    d0_en = 1; d0_rd = 1;
    @(posedge clk); #1 d0_en = 0;
    chk("w0_rd_no_early", {15'b0, d0_ready}, 16'h0000);
    @(posedge clk); #1;
    chk("w0_rd_ready", {15'b0, d0_ready}, 16'h0001);
    chk("w0_rd_data", d0_dout, 16'hBEEF);
    @(posedge clk); #1;
    d0_en = 1; d0_rd = 1;
    pat = 6'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      pat[i] = d0_ready;
    end
    d0_en = 0;
    chk("w0_held_pattern", {10'b0, pat}, 16'h002A);
    chk("w0_held_data", d0_dout, 16'hBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
